// File: rtl/mem_fill_arbiter.sv
// Arbitrates D-miss fills, D write-through stores and I-miss fills onto one
// pipelined memory port; fills stream a whole block back into the requesting cache.
module mem_fill_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int BLK_WORDS = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_miss,
    input  logic [ADDR_W-1:0]            i_miss_addr,
    input  logic                         d_miss,
    input  logic [ADDR_W-1:0]            d_miss_addr,
    input  logic                         d_wr,
    input  logic [ADDR_W-1:0]            d_wr_addr,
    input  logic [DATA_W-1:0]            d_wr_data,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic                         mem_rd_valid,
    input  logic [DATA_W-1:0]            mem_rdata,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic                         i_fill_we,
    output logic                         d_fill_we,
    output logic                         i_fill_done,
    output logic                         d_fill_done,
    output logic                         d_wr_ack,
    output logic                         busy
);

    localparam int IDX_W = $clog2(BLK_WORDS);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0]  BLK_CNT  = CNT_W'(BLK_WORDS);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BLK_WORDS - 1);
    // Clears the byte offset within a block (word index plus byte-in-word bit).
    localparam logic [ADDR_W-1:0] BLK_MASK  = ~ADDR_W'((1 << (IDX_W + 1)) - 1);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        FILL_D,
        FILL_I,
        WRITE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    iss_cnt_q, iss_cnt_d;
    logic [CNT_W-1:0]    rcv_cnt_q, rcv_cnt_d;
    logic [ADDR_W-1:0]   base_q, base_d;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            iss_cnt_q <= '0;
            rcv_cnt_q <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            iss_cnt_q <= iss_cnt_d;
            rcv_cnt_q <= rcv_cnt_d;
            base_q    <= base_d;
        end
    end

    // NOTE: every signal written below gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        iss_cnt_d   = iss_cnt_q;
        rcv_cnt_d   = rcv_cnt_q;
        base_d      = base_q;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        fill_data   = '0;
        fill_idx    = '0;
        i_fill_we   = 1'b0;
        d_fill_we   = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        d_wr_ack    = 1'b0;

        unique case (state_q)
            IDLE: begin
                iss_cnt_d = '0;
                rcv_cnt_d = '0;
                if (d_miss) begin
                    state_d = FILL_D;
                    base_d  = d_miss_addr & BLK_MASK;
                end else if (d_wr) begin
                    state_d = WRITE;
                end else if (i_miss) begin
                    state_d = FILL_I;
                    base_d  = i_miss_addr & BLK_MASK;
                end
            end

            FILL_D, FILL_I: begin
                if (iss_cnt_q < BLK_CNT) begin
                    mem_en    = 1'b1;
                    mem_addr  = base_q | ADDR_W'({iss_cnt_q[IDX_W-1:0], 1'b0});
                    iss_cnt_d = iss_cnt_q + CNT_W'(1);
                end
                // Returns beyond the block length are stray and dropped.
                if (mem_rd_valid && (rcv_cnt_q < BLK_CNT)) begin
                    fill_data = mem_rdata;
                    fill_idx  = rcv_cnt_q[IDX_W-1:0];
                    rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
                    if (state_q == FILL_D) d_fill_we = 1'b1;
                    else                   i_fill_we = 1'b1;
                    if (rcv_cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        if (state_q == FILL_D) d_fill_done = 1'b1;
                        else                   i_fill_done = 1'b1;
                    end
                end
            end

            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = d_wr_addr & WORD_MASK;
                mem_wdata = d_wr_data;
                d_wr_ack  = 1'b1;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// Scoreboard bench for mem_fill_arbiter: stimulus pushes expected memory issues
// and fill writes; a negedge monitor pops and compares them as the DUT emits them.
module tb_mem_fill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_miss, d_miss, d_wr;
    logic [15:0] i_miss_addr, d_miss_addr, d_wr_addr, d_wr_data;
    logic        mem_en, mem_wr, mem_rd_valid;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, fill_data;
    logic [2:0]  fill_idx;
    logic        i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy;
    logic        extra_valid;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_fill_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_miss       (i_miss),
        .i_miss_addr  (i_miss_addr),
        .d_miss       (d_miss),
        .d_miss_addr  (d_miss_addr),
        .d_wr         (d_wr),
        .d_wr_addr    (d_wr_addr),
        .d_wr_data    (d_wr_data),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd_valid (mem_rd_valid),
        .mem_rdata    (mem_rdata),
        .fill_data    (fill_data),
        .fill_idx     (fill_idx),
        .i_fill_we    (i_fill_we),
        .d_fill_we    (d_fill_we),
        .i_fill_done  (i_fill_done),
        .d_fill_done  (d_fill_done),
        .d_wr_ack     (d_wr_ack),
        .busy         (busy)
    );

    // Memory model: a read issued in one cycle returns four cycles later with
    // word[a] = a ^ 16'hA5A5. It is deliberately not reset.
    bit          pv [4];
    logic [15:0] pa [4];
    always @(posedge clk) begin
        pv[0] <= mem_en && !mem_wr;
        pa[0] <= mem_addr;
        for (int k = 1; k < 4; k++) begin
            pv[k] <= pv[k-1];
            pa[k] <= pa[k-1];
        end
    end
    assign mem_rd_valid = pv[3] | extra_valid;
    assign mem_rdata    = extra_valid ? 16'hDEAD : (pv[3] ? (pa[3] ^ 16'hA5A5) : 16'h0000);

    logic [58:0] out_vec;
    assign out_vec = {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_idx,
                      i_fill_we, d_fill_we, i_fill_done, d_fill_done, d_wr_ack, busy};

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          cyc;
    } mem_exp_t;

    typedef struct {
        logic        is_i;
        logic [2:0]  idx;
        logic [15:0] data;
        logic        done;
        int          cyc;
    } fill_exp_t;

    mem_exp_t  mem_q [$];
    fill_exp_t fill_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic stray(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event, out=%0h (cyc %0d)", name, out_vec, cyc);
    endtask

    // Monitor: compares every memory strobe and every fill write against the queues.
    mem_exp_t  me;
    fill_exp_t fe;
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_en) begin
                if (mem_q.size() == 0) stray("mem_en");
                else begin
                    me = mem_q.pop_front();
                    check("mem_wr",    mem_wr,    me.wr);
                    check("mem_addr",  mem_addr,  me.addr);
                    check("mem_wdata", mem_wdata, me.wdata);
                    check("d_wr_ack",  d_wr_ack,  me.wr);
                    check("mem_cycle", cyc,       me.cyc);
                end
            end else if (d_wr_ack) stray("d_wr_ack");

            if (i_fill_we || d_fill_we) begin
                if (fill_q.size() == 0) stray("fill_we");
                else begin
                    fe = fill_q.pop_front();
                    check("fill_we_sel", {i_fill_we, d_fill_we}, fe.is_i ? 2'b10 : 2'b01);
                    check("fill_idx",    fill_idx,  fe.idx);
                    check("fill_data",   fill_data, fe.data);
                    check("fill_done",   {i_fill_done, d_fill_done},
                          fe.done ? (fe.is_i ? 2'b10 : 2'b01) : 2'b00);
                    check("fill_cycle",  cyc,       fe.cyc);
                end
            end else if (i_fill_done || d_fill_done) stray("fill_done");
        end
    end

    task automatic push_mem(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                            input int c);
        mem_exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.cyc = c;
        mem_q.push_back(e);
    endtask

    // Expected traffic of a fill whose request was sampled at the edge giving cyc==t;
    // only the first n_rcv words are expected back in the cache.
    task automatic push_fill(input logic is_i, input logic [15:0] base, input int t,
                             input int n_rcv);
        fill_exp_t f;
        logic [15:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 16'(base + 2 * k);
            push_mem(1'b0, a, 16'h0000, t + k);
            if (k < n_rcv) begin
                f.is_i = is_i; f.idx = 3'(k); f.data = a ^ 16'hA5A5;
                f.done = (k == 7); f.cyc = t + 4 + k;
                fill_q.push_back(f);
            end
        end
    endtask

    // Waits for the request set up beforehand to be sampled; returns that edge's cycle.
    task automatic start(output int t);
        @(posedge clk);
        #1;
        t = cyc;
    endtask

    // Lands 2 time units after the negedge inside cycle n (n must be in the future).
    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int t;
        rst = 1'b1;
        i_miss = 0; d_miss = 0; d_wr = 0; extra_valid = 0;
        i_miss_addr = '0; d_miss_addr = '0; d_wr_addr = '0; d_wr_data = '0;
        repeat (5) @(negedge clk);
        check("reset_outputs", out_vec, 59'h0);
        #2 rst = 1'b0;

        // 1: basic D fill, then a 9th valid right after the block completed.
        d_miss = 1; d_miss_addr = 16'h1236;
        start(t);
        push_fill(1'b0, 16'h1230, t, 8);
        wait_cyc(t + 4);
        check("t1_first_word", fill_data, 16'hB795);
        wait_cyc(t + 11);
        check("t1_last_word", fill_data, 16'hB79B);
        check("t1_done", d_fill_done, 1'b1);
        d_miss = 0;
        wait_cyc(t + 12);
        check("t1_busy_low", busy, 1'b0);
        extra_valid = 1;
        wait_cyc(t + 13);
        check("t5_after_done_no_we", {i_fill_we, d_fill_we}, 2'b00);
        extra_valid = 0;

        // 2: simultaneous D and I miss; D first, I issues begin two cycles after done.
        d_miss = 1; d_miss_addr = 16'h4A1E;
        i_miss = 1; i_miss_addr = 16'h7C08;
        start(t);
        push_fill(1'b0, 16'h4A10, t, 8);
        push_fill(1'b1, 16'h7C00, t + 13, 8);
        wait_cyc(t + 11);
        d_miss = 0;
        wait_cyc(t + 12);
        check("t2_busy_gap", busy, 1'b0);
        wait_cyc(t + 24);
        check("t2_i_done", i_fill_done, 1'b1);
        i_miss = 0;
        wait_cyc(t + 25);

        // 3: single write-through store.
        d_wr = 1; d_wr_addr = 16'h0041; d_wr_data = 16'hBEEF;
        start(t);
        push_mem(1'b1, 16'h0040, 16'hBEEF, t);
        @(negedge clk);
        #2;
        check("t3_ack", d_wr_ack, 1'b1);
        d_wr = 0;
        wait_cyc(t + 1);
        check("t3_busy_low", busy, 1'b0);

        // 4: reset after the 4th fill word; later returns must be ignored.
        d_miss = 1; d_miss_addr = 16'h2222;
        start(t);
        push_fill(1'b0, 16'h2220, t, 4);
        wait_cyc(t + 7);
        rst = 1'b1;
        d_miss = 0;
        #1;
        check("t4_outputs_in_reset", out_vec, 59'h0);
        wait_cyc(t + 8);
        rst = 1'b0;
        wait_cyc(t + 9);
        check("t4_stale_no_we", {i_fill_we, d_fill_we, busy}, 3'b000);
        wait_cyc(t + 13);
        i_miss = 1; i_miss_addr = 16'h8F02;
        start(t);
        push_fill(1'b1, 16'h8F00, t, 8);
        wait_cyc(t + 11);
        i_miss = 0;
        wait_cyc(t + 13);

        // 5: spurious valid while idle.
        extra_valid = 1;
        @(negedge clk);
        #1;
        check("t5_idle_no_we", {i_fill_we, d_fill_we, i_fill_done, d_fill_done}, 4'h0);
        #1 extra_valid = 0;

        // 6: d_miss held through done starts a second fill after one idle cycle.
        d_miss = 1; d_miss_addr = 16'h0FF4;
        start(t);
        push_fill(1'b0, 16'h0FF0, t, 8);
        push_fill(1'b0, 16'h0FF0, t + 13, 8);
        wait_cyc(t + 11);
        check("t6_busy_at_done", busy, 1'b1);
        wait_cyc(t + 12);
        check("t6_busy_gap", busy, 1'b0);
        wait_cyc(t + 13);
        check("t6_busy_again", busy, 1'b1);
        wait_cyc(t + 24);
        d_miss = 0;
        wait_cyc(t + 27);

        check("mem_q_drained",  mem_q.size(),  0);
        check("fill_q_drained", fill_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
